// File: rtl/mult_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mult_rr_scheduler
//
// Shares one pipelined signed multiplier among NUM_REQ requesters. Each enabled
// cycle, at most one operand pair is issued, chosen round-robin. A {valid, tag}
// shift register runs in lockstep with the multiplier pipeline, so each product
// is routed back to the requester that issued it.
//
// Parameters
//   NUM_REQ      : number of requesters (>= 2)
//   IN_WIDTH     : signed operand width (matches the multiplier)
//   PIPE_LATENCY : multiplier latency in enabled cycles (>= 1)
//
// Ports
//   clk, reset   : clock; synchronous active-high reset (shared with multiplier)
//   enable       : global clock enable (shared with multiplier)
//   req          : per-requester request level
//   reqA, reqB   : packed operands, slot i at [i*IN_WIDTH +: IN_WIDTH]
//   ack          : one-hot, operands of requester i were accepted
//   mulInReady   : issue strobe to the multiplier
//   mulA, mulB   : operands to the multiplier
//   mulOutReady  : product strobe from the multiplier
//   mulDP        : product from the multiplier
//   resValid     : one-hot owner of resDP (combinational)
//   resDP        : product pass-through (combinational)
//   busy         : at least one operation in flight
//   seqError     : sticky pipeline-alignment error (only with MULT_SCHED_CHECK_EN)
//
// Optional feature macro: MULT_SCHED_CHECK_EN
// -----------------------------------------------------------------------------
module mult_rr_scheduler #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned IN_WIDTH     = 10,
   parameter int unsigned PIPE_LATENCY = 17
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*IN_WIDTH-1:0]  reqA,
   input  logic [NUM_REQ*IN_WIDTH-1:0]  reqB,
   output logic [NUM_REQ-1:0]           ack,
   output logic                         mulInReady,
   output logic [IN_WIDTH-1:0]          mulA,
   output logic [IN_WIDTH-1:0]          mulB,
   input  logic                         mulOutReady,
   input  logic [2*IN_WIDTH-1:0]        mulDP,
   output logic [NUM_REQ-1:0]           resValid,
   output logic [2*IN_WIDTH-1:0]        resDP,
   output logic                         busy
`ifdef MULT_SCHED_CHECK_EN
   ,
   output logic                         seqError
`endif
);

   localparam int unsigned TAG_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned SUM_W  = TAG_W + 1;
   localparam int unsigned PIPE_W = PIPE_LATENCY * TAG_W;

   // Elaboration-time parameter sanity
   generate
      if (NUM_REQ < 2) begin : g_bad_num_req
         $error("mult_rr_scheduler: NUM_REQ must be at least 2");
      end
      if (PIPE_LATENCY < 1) begin : g_bad_latency
         $error("mult_rr_scheduler: PIPE_LATENCY must be at least 1");
      end
   endgenerate

   // Registered state
   logic [NUM_REQ-1:0]                   ack_q,        ack_d;
   logic [NUM_REQ-1:0]                   last_grant_q, last_grant_d;
   logic [TAG_W-1:0]                     ptr_q,        ptr_d;
   logic                                 in_ready_q,   in_ready_d;
   logic [IN_WIDTH-1:0]                  mul_a_q,      mul_a_d;
   logic [IN_WIDTH-1:0]                  mul_b_q,      mul_b_d;
   logic [TAG_W-1:0]                     tag_q,        tag_d;
   logic [PIPE_LATENCY-1:0]              vld_pipe_q,   vld_pipe_d;
   logic [PIPE_LATENCY-1:0][TAG_W-1:0]   tag_pipe_q,   tag_pipe_d;
   logic                                 busy_q,       busy_d;

   // Arbitration signals
   logic [NUM_REQ-1:0]                   eligible_c;
   logic                                 grant_vld_c;
   logic [TAG_W-1:0]                     grant_idx_c;
   logic [NUM_REQ-1:0]                   grant_oh_c;
   logic [SUM_W-1:0]                     ptr_inc_c;

   // Return path
   logic [NUM_REQ-1:0]                   res_valid_c;
   logic                                 head_vld_c;
   logic [TAG_W-1:0]                     head_tag_c;

   assign head_vld_c = vld_pipe_q[PIPE_LATENCY-1];
   assign head_tag_c = tag_pipe_q[PIPE_LATENCY-1];

   // Round-robin search: first eligible requester at or after the pointer.
   // The last-grant mask keeps one requester from winning twice in a row.
   always_comb begin
      logic [SUM_W-1:0] cand;
      eligible_c  = req & ~last_grant_q;
      grant_vld_c = 1'b0;
      grant_idx_c = '0;
      cand        = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_q} + SUM_W'(k);
         if (cand >= SUM_W'(NUM_REQ)) begin
            cand = cand - SUM_W'(NUM_REQ);
         end
         if (!grant_vld_c && eligible_c[cand[TAG_W-1:0]]) begin
            grant_vld_c = 1'b1;
            grant_idx_c = cand[TAG_W-1:0];
         end
      end
   end

   // One-hot grant and pointer advance (g + 1) mod NUM_REQ
   always_comb begin
      grant_oh_c = '0;
      ptr_inc_c  = {1'b0, grant_idx_c} + SUM_W'(1);
      if (grant_vld_c) begin
         grant_oh_c = NUM_REQ'(1) << grant_idx_c;
      end
      if (ptr_inc_c == SUM_W'(NUM_REQ)) begin
         ptr_inc_c = '0;
      end
   end

   // Next-state logic; everything holds when enable is low
   always_comb begin
      ack_d        = ack_q;
      last_grant_d = last_grant_q;
      ptr_d        = ptr_q;
      in_ready_d   = in_ready_q;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      tag_d        = tag_q;
      vld_pipe_d   = vld_pipe_q;
      tag_pipe_d   = tag_pipe_q;
      busy_d       = busy_q;

      if (enable) begin
         ack_d        = grant_oh_c;
         last_grant_d = grant_oh_c;
         in_ready_d   = grant_vld_c;
         if (grant_vld_c) begin
            mul_a_d = reqA[grant_idx_c*IN_WIDTH +: IN_WIDTH];
            mul_b_d = reqB[grant_idx_c*IN_WIDTH +: IN_WIDTH];
            tag_d   = grant_idx_c;
            ptr_d   = ptr_inc_c[TAG_W-1:0];
         end

         // The multiplier samples mulInReady/mulA/mulB on this edge, so the
         // tag pipe samples the same registered strobe and its tag.
         vld_pipe_d = PIPE_LATENCY'({vld_pipe_q, in_ready_q});
         tag_pipe_d = PIPE_W'({tag_pipe_q, tag_q});

         busy_d = in_ready_d | (|vld_pipe_d);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         ack_q        <= '0;
         last_grant_q <= '0;
         ptr_q        <= '0;
         in_ready_q   <= 1'b0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         tag_q        <= '0;
         vld_pipe_q   <= '0;
         tag_pipe_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         ack_q        <= ack_d;
         last_grant_q <= last_grant_d;
         ptr_q        <= ptr_d;
         in_ready_q   <= in_ready_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         tag_q        <= tag_d;
         vld_pipe_q   <= vld_pipe_d;
         tag_pipe_q   <= tag_pipe_d;
         busy_q       <= busy_d;
      end
   end

`ifdef MULT_SCHED_CHECK_EN
   // Alignment checker: the multiplier strobe must track the tag pipe head
   logic seq_error_q;
   logic mismatch_c;

   assign mismatch_c = enable & (mulOutReady ^ head_vld_c);

   always_ff @(posedge clk) begin
      if (reset) begin
         seq_error_q <= 1'b0;
      end else if (mismatch_c) begin
         seq_error_q <= 1'b1;
      end
   end

   assign seqError = seq_error_q;
`endif

   // Return decode: product goes to the owner recorded in the tag pipe head
   always_comb begin
      res_valid_c = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (mulOutReady && (head_tag_c == TAG_W'(i))) begin
            res_valid_c[i] = 1'b1;
         end
      end
`ifdef MULT_SCHED_CHECK_EN
      if (mismatch_c) begin
         res_valid_c = '0;
      end
`endif
   end

   assign ack        = ack_q;
   assign mulInReady = in_ready_q;
   assign mulA       = mul_a_q;
   assign mulB       = mul_b_q;
   assign resValid   = res_valid_c;
   assign resDP      = mulDP;
   assign busy       = busy_q;

endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Shares one pipelined signed multiplier (registered-input multiplier with fixed latency) among NUM_REQ requesters.
- Round-robin issue of at most one operand pair per enabled cycle.
- Carries a requester tag alongside the multiplier pipeline so each product returns to its owner.
- Sits between per-channel datapath blocks and the single shared multiplier instance.

Parameters:
- NUM_REQ, 4: number of requesters, at least 2.
- IN_WIDTH, 10: operand width, signed. Must match the multiplier's IN_WIDTH.
- PIPE_LATENCY, 17: multiplier latency in enabled cycles (its input register depth plus its multiplier pipe depth). Must be at least 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset; also drives the multiplier's reset.
- enable  in  1  global clock enable; also drives the multiplier's enable.
- req  in  NUM_REQ  request level, one bit per requester.
- reqA  in  NUM_REQ*IN_WIDTH  packed A operands; slot i at [i*IN_WIDTH +: IN_WIDTH].
- reqB  in  NUM_REQ*IN_WIDTH  packed B operands, same packing as reqA.
- ack  out  NUM_REQ  one-hot; operands of requester i were accepted.
- mulInReady  out  1  to the multiplier's inReady.
- mulA  out  IN_WIDTH  to the multiplier's A.
- mulB  out  IN_WIDTH  to the multiplier's B.
- mulOutReady  in  1  from the multiplier's outReady.
- mulDP  in  2*IN_WIDTH  from the multiplier's DP.
- resValid  out  NUM_REQ  one-hot; resDP belongs to requester i.
- resDP  out  2*IN_WIDTH  product pass-through.
- busy  out  1  at least one operation in flight.

Behaviour:
- Reset:
  - ack, mulInReady, mulA, mulB, the tag/valid pipeline, the last-grant mask and busy all clear to 0.
  - Round-robin pointer clears to 0, giving requester 0 top priority.
  - In-flight operations are discarded; no resValid is produced for them after reset.
- Stall (enable=0): all registers hold, including ack and mulInReady. The acceptance event is counted only once, on an enabled cycle.
- Issue, on each enabled edge:
  - eligible = req & ~lastGrant.
  - Grant g is the first set bit of eligible, searching from the pointer upward with wrap-around.
  - If g exists: mulInReady<=1, mulA<=reqA[g], mulB<=reqB[g], ack<=onehot(g), lastGrant<=onehot(g), pointer<=(g+1) mod NUM_REQ.
  - If no bit is eligible: mulInReady<=0, ack<=0, lastGrant<=0, pointer unchanged.
- Requester rules:
  - Operands are sampled on the granting edge; ack is high in the following cycle.
  - The requester must drop req, or present its next operands, by the end of that ack cycle.
  - The lastGrant mask blocks back-to-back grants to the same requester, so one requester gets at most one grant every 2 enabled cycles.
  - Full throughput (1 per cycle) needs at least 2 active requesters.
- Tag pipeline:
  - A shift register of depth PIPE_LATENCY carrying {valid, tag}, advanced only on enabled edges.
  - It is loaded with {mulInReady, tag of g} in lockstep with the multiplier.
- Return path (combinational): resValid[i] = mulOutReady & tagOut==i; resDP = mulDP.
- Latency: resValid arrives exactly PIPE_LATENCY enabled cycles after the ack cycle. Return order equals issue order.
- busy = OR of mulInReady and all valid bits in the tag pipeline.
- Arithmetic: the scheduler does none; operands and products pass unmodified (signed).
- Simultaneous events:
  - An issue and a return in the same cycle are independent.
  - Reset overrides enable.

Optional Feature:
- Macro MULT_SCHED_CHECK_EN.
- Defined:
  - Adds output seqError (1 bit), sticky, cleared only by reset.
  - Sets on any enabled cycle where mulOutReady differs from the tag pipeline's head valid bit.
  - When it sets, resValid is forced to 0 for that cycle.
- Undefined: port and checker are absent; resValid derives from mulOutReady and tagOut only.

Test Plan:
All scenarios use NUM_REQ=4, IN_WIDTH=10, PIPE_LATENCY=3 and a behavioural multiplier model.
- Single request: reset, then req=0001, A0=5, B0=-3 -> next cycle ack=0001, mulInReady=1, mulA=5, mulB=-3; 3 cycles later resValid=0001, resDP=-15.
- Full contention: req=1111 held, A_i=i+1, B_i=2 -> grants 0,1,2,3,0,... one per cycle; mulInReady continuous; results 2,4,6,8 return in that order to the matching resValid bits.
- Lone requester: only req[2] held -> ack=0100 every other cycle; mulInReady toggles 1,0,1,0.
- Stall: enable=0 for 2 cycles with 2 operations in flight -> no new grants, tags frozen; results still return after exactly 3 enabled cycles with the correct tags.
- Reset mid-flight: reset asserted with 2 operations in flight -> busy=0, no resValid afterwards; with req=1111 the next grant goes to requester 0.
- MULT_SCHED_CHECK_EN defined: model asserts outReady 1 cycle early -> seqError=1 and remains 1 until reset; resValid=0 in that cycle.
